// File: rtl/tl_pkg.sv
// TileLink A/D channel payload types and opcodes shared by the arbiter and its users.
package tl_pkg;

  localparam int TL_SRC_W = 4;
  localparam int TL_SZ_W  = 4;
  localparam int TL_AW    = 32;
  localparam int TL_DW    = 64;

  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          param;
    logic [TL_SZ_W-1:0]  size;
    logic [TL_SRC_W-1:0] source;
    logic [TL_AW-1:0]    address;
    logic [TL_DW/8-1:0]  mask;
    logic [TL_DW-1:0]    data;
  } A_chan_bits_t;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          param;
    logic [TL_SZ_W-1:0]  size;
    logic [TL_SRC_W-1:0] source;
    logic                sink;
    logic                denied;
    logic [TL_DW-1:0]    data;
    logic                error;
  } D_chan_bits_t;

endpackage

// File: rtl/tl_a_d_arbiter.sv
// N-to-1 TileLink A arbiter with burst lock and source-indexed D response routing.
// Define TL_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest) instead of round-robin.
module tl_a_d_arbiter #(
  parameter int N_REQ      = 4,
  parameter int SRC_W      = 4,
  parameter int BEAT_BYTES = 8,
  parameter int MAX_SIZE   = 6
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [N_REQ-1:0]                     req_a_valid_i,
  output logic [N_REQ-1:0]                     req_a_ready_o,
  input  tl_pkg::A_chan_bits_t [N_REQ-1:0]     req_a_bits_i,
  output logic [N_REQ-1:0]                     req_d_valid_o,
  input  logic [N_REQ-1:0]                     req_d_ready_i,
  output tl_pkg::D_chan_bits_t [N_REQ-1:0]     req_d_bits_o,
  output logic                                 A_valid_o,
  input  logic                                 A_ready_i,
  output tl_pkg::A_chan_bits_t                 A_bits_o,
  input  logic                                 D_valid_i,
  output logic                                 D_ready_o,
  input  tl_pkg::D_chan_bits_t                 D_bits_i,
  output logic                                 unexp_d_o
);

  localparam int OWN_W = $clog2(N_REQ);
  localparam int NSRC  = 1 << SRC_W;
  localparam int CNT_W = MAX_SIZE + 1;
  localparam int BB_LG = $clog2(BEAT_BYTES);

  function automatic logic [CNT_W-1:0] beats_f(input logic [tl_pkg::TL_SZ_W-1:0] size,
                                               input logic multi);
    int sz;
    sz = int'(size);
    if (!multi || sz <= BB_LG) return CNT_W'(1);
    return CNT_W'(1 << (sz - BB_LG));
  endfunction

  logic [NSRC-1:0]            tbl_v_q;
  logic [NSRC-1:0][OWN_W-1:0] tbl_own_q;
  logic                       lock_q, hold_q, unexp_q;
  logic [CNT_W-1:0]           a_cnt_q, d_cnt_q;
  logic [OWN_W-1:0]           gnt_q, rr_ptr, arb_idx, gnt;
  logic [N_REQ-1:0]           elig;
  logic                       arb_hit, frozen, a_vld, a_hs, a_last, a_put;
  logic [CNT_W-1:0]           a_beats, d_beats;
  logic [SRC_W-1:0]           a_src, d_src;
  logic [OWN_W-1:0]           d_own;
  logic                       d_hit, d_hs, d_last;
  int                         k;

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++)
      elig[i] = req_a_valid_i[i] && !tbl_v_q[req_a_bits_i[i].source[SRC_W-1:0]];
  end

  // Scan downwards so the smallest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    arb_idx = '0;
    arb_hit = 1'b0;
    k       = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = int'(rr_ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (elig[k]) begin
        arb_idx = OWN_W'(k);
        arb_hit = 1'b1;
      end
    end
  end

  // A burst in progress holds its grant; a stalled first beat is held the same way.
  assign frozen   = lock_q || hold_q;
  assign gnt      = frozen ? gnt_q : arb_idx;
  assign a_vld    = frozen ? req_a_valid_i[gnt_q] : arb_hit;
  assign A_valid_o = a_vld;
  assign A_bits_o  = req_a_bits_i[gnt];
  assign a_hs     = a_vld && A_ready_i;
  assign a_src    = A_bits_o.source[SRC_W-1:0];
  assign a_put    = (A_bits_o.opcode == tl_pkg::PutFullData) ||
                    (A_bits_o.opcode == tl_pkg::PutPartialData);
  assign a_beats  = beats_f(A_bits_o.size, a_put);
  assign a_last   = lock_q ? (a_cnt_q == CNT_W'(1)) : (a_beats == CNT_W'(1));

  always_comb begin
    req_a_ready_o      = '0;
    req_a_ready_o[gnt] = A_ready_i && a_vld;
  end

  assign d_src   = D_bits_i.source[SRC_W-1:0];
  assign d_own   = tbl_own_q[d_src];
  assign d_hit   = tbl_v_q[d_src];
  assign D_ready_o = d_hit ? req_d_ready_i[d_own] : 1'b1;
  assign d_hs    = D_valid_i && D_ready_o && d_hit;
  assign d_beats = beats_f(D_bits_i.size, D_bits_i.opcode == tl_pkg::AccessAckData);
  assign d_last  = (d_cnt_q != '0) ? (d_cnt_q == CNT_W'(1)) : (d_beats == CNT_W'(1));
  assign unexp_d_o = unexp_q;

  always_comb begin
    req_d_valid_o        = '0;
    req_d_valid_o[d_own] = D_valid_i && d_hit;
    for (int i = 0; i < N_REQ; i++) req_d_bits_o[i] = D_bits_i;
  end

`ifdef TL_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [OWN_W-1:0] rr_ptr_q;
  assign rr_ptr = rr_ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      rr_ptr_q <= '0;
    else if (a_hs && a_last)
      rr_ptr_q <= (gnt == OWN_W'(N_REQ - 1)) ? '0 : gnt + 1'b1;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= 1'b0;
      hold_q    <= 1'b0;
      gnt_q     <= '0;
      a_cnt_q   <= '0;
      d_cnt_q   <= '0;
      unexp_q   <= 1'b0;
      tbl_v_q   <= '0;
      tbl_own_q <= '0;
    end else begin
      gnt_q   <= gnt;
      hold_q  <= a_vld && !A_ready_i;
      unexp_q <= D_valid_i && !d_hit;
      if (a_hs) begin
        if (lock_q) begin
          a_cnt_q <= a_cnt_q - 1'b1;
          if (a_cnt_q == CNT_W'(1)) lock_q <= 1'b0;
        end else if (a_beats > CNT_W'(1)) begin
          lock_q  <= 1'b1;
          a_cnt_q <= a_beats - 1'b1;
        end
      end
      if (d_hs) begin
        if (d_cnt_q != '0)
          d_cnt_q <= d_cnt_q - 1'b1;
        else if (d_beats > CNT_W'(1))
          d_cnt_q <= d_beats - 1'b1;
      end
      // Clear precedes set so a same-cycle retire and reissue leaves the entry valid.
      if (d_hs && d_last) tbl_v_q[d_src] <= 1'b0;
      if (a_hs && !lock_q) begin
        tbl_v_q[a_src]   <= 1'b1;
        tbl_own_q[a_src] <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_tl_a_d_arbiter.sv
// Directed bench for tl_a_d_arbiter: single Get, contention, burst lock, busy source,
// unexpected D and reset mid-burst.
module tb_tl_a_d_arbiter;
  import tl_pkg::*;

  logic                   clk, rst_n;
  logic [3:0]             a_v, a_r, d_v, d_r;
  A_chan_bits_t [3:0]     a_bits;
  D_chan_bits_t [3:0]     d_bits_o;
  logic                   A_valid, A_ready, D_valid, D_ready, unexp;
  A_chan_bits_t           A_bits;
  D_chan_bits_t           D_bits;

  int n_tests = 0;
  int n_fail  = 0;
  int nsrc;
  logic [3:0] exp_g [4];
  logic [3:0] g;

  tl_a_d_arbiter #(.N_REQ(4), .SRC_W(4), .BEAT_BYTES(8), .MAX_SIZE(6)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_a_valid_i(a_v), .req_a_ready_o(a_r), .req_a_bits_i(a_bits),
    .req_d_valid_o(d_v), .req_d_ready_i(d_r), .req_d_bits_o(d_bits_o),
    .A_valid_o(A_valid), .A_ready_i(A_ready), .A_bits_o(A_bits),
    .D_valid_i(D_valid), .D_ready_o(D_ready), .D_bits_i(D_bits),
    .unexp_d_o(unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_a(input int i, input logic [2:0] op, input int sz, input int src);
    a_bits[i]        = '0;
    a_bits[i].opcode = op;
    a_bits[i].size   = 4'(sz);
    a_bits[i].source = 4'(src);
    a_bits[i].address = 32'(i * 32'h100);
    a_v[i]           = 1'b1;
  endtask

  task automatic set_d(input logic [2:0] op, input int sz, input int src);
    D_bits        = '0;
    D_bits.opcode = op;
    D_bits.size   = 4'(sz);
    D_bits.source = 4'(src);
    D_valid       = 1'b1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; a_v = '0; D_valid = 1'b0; A_ready = 1'b0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; a_v = '0; a_bits = '0; d_r = 4'hF; A_ready = 1'b0;
    D_valid = 1'b0; D_bits = '0;
    @(negedge clk); #1;
    chk("rst_a_valid", A_valid, 0);
    chk("rst_a_ready", a_r, 0);
    chk("rst_d_ready", D_ready, 1);
    chk("rst_d_valid", d_v, 0);
    chk("rst_unexp", unexp, 0);
    do_reset;

    // Single Get, req 1 source 3
    A_ready = 1'b1; set_a(1, Get, 3, 3);
    #1 chk("get_a_valid", A_valid, 1);
    chk("get_ready", a_r, 4'b0010);
    chk("get_src", A_bits.source, 3);
    tick; a_v = '0;
    set_d(AccessAckData, 3, 3);
    #1 chk("get_d_route", d_v, 4'b0010);
    chk("get_d_ready", D_ready, 1);
    tick;
    #1 chk("get_entry_clr", d_v, 0);
    tick; D_valid = 1'b0;

    // Contention
    do_reset;
    A_ready = 1'b1; set_a(0, Get, 3, 0); set_a(2, Get, 3, 2); set_a(3, Get, 3, 3);
`ifdef TL_ARB_FIXED_PRIO_EN
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_g = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};
`endif
    nsrc = 8;
    for (int j = 0; j < 4; j++) begin
      #1 chk($sformatf("rr_grant%0d", j), a_r, exp_g[j]);
      g = a_r;
      tick;
      for (int i = 0; i < 4; i++)
        if (g[i]) begin a_bits[i].source = 4'(nsrc); nsrc++; end
    end
    a_v = '0;

    // Burst lock with a stall on beat 4
    do_reset;
    A_ready = 1'b1; set_a(0, PutFullData, 6, 1); set_a(1, Get, 3, 2);
    for (int b = 0; b < 8; b++) begin
      if (b == 3) begin
        A_ready = 1'b0;
        #1 chk("hold_valid", A_valid, 1);
        chk("hold_src", A_bits.source, 1);
        chk("hold_ready", a_r, 0);
        tick; A_ready = 1'b1;
      end
      #1 chk($sformatf("burst_beat%0d", b), a_r, 4'b0001);
      tick;
    end
    a_v[0] = 1'b0;
    #1 chk("after_burst", a_r, 4'b0010);
    tick; a_v = '0;

    // Busy source
    do_reset;
    A_ready = 1'b1; set_a(2, Get, 3, 5);
    #1 chk("busy_first", a_r, 4'b0100);
    tick;
    #1 chk("busy_stall", a_r, 0);
    chk("busy_no_valid", A_valid, 0);
    set_a(0, Get, 3, 6);
    #1 chk("busy_other", a_r, 4'b0001);
    tick; a_v[0] = 1'b0;
    set_d(AccessAck, 0, 5);
    #1 chk("busy_d_route", d_v, 4'b0100);
    chk("busy_still", a_r, 0);
    tick; D_valid = 1'b0;
    #1 chk("busy_release", a_r, 4'b0100);
    tick; a_v = '0;

    // Unexpected D
    do_reset;
    set_d(AccessAckData, 3, 9);
    #1 chk("unexp_ready", D_ready, 1);
    chk("unexp_no_route", d_v, 0);
    chk("unexp_before", unexp, 0);
    tick; D_valid = 1'b0;
    #1 chk("unexp_pulse", unexp, 1);
    tick;
    #1 chk("unexp_clear", unexp, 0);

    // Async reset after beat 3 of an 8-beat burst
    do_reset;
    A_ready = 1'b1; set_a(0, PutFullData, 6, 1); set_a(1, Get, 3, 2);
    tick; tick; tick;
    #1 chk("rst_mid_locked", a_r, 4'b0001);
    rst_n = 1'b0; a_v[0] = 1'b0;
    #1 chk("rst_mid_unlock", a_r, 4'b0010);
    chk("rst_mid_valid", A_valid, 1);
    set_d(AccessAckData, 6, 1);
    #1 chk("rst_mid_tbl", d_v, 0);
    chk("rst_mid_dready", D_ready, 1);
    D_valid = 1'b0;
    tick;
    rst_n = 1'b1; a_v[0] = 1'b1;
    #1 chk("rst_next_grant", a_r, 4'b0001);
    tick; a_v = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
